// File: rtl/hazard_unit_pkg.sv
// Shared types for the dual-ISA pipeline hazard controller.
// Forwarding selects, FSM states and default register-index constants.
package hazard_pkg;

  localparam int REG_W_DEF  = 5;
  localparam int PC_REG_DEF = 15;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    PCW_E = 2'b01,
    PCW_M = 2'b10,
    PCW_W = 2'b11
  } hz_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard controller bundle: register ids and status in, stall/flush/forward controls out.
// master = the pipeline stages, slave = hazard_unit.
interface hazard_if #(
  parameter int REG_W = 5
);
  import hazard_pkg::*;

  logic             arm;
  logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E;
  logic [REG_W-1:0] RdE, RdM, RdW;
  logic             LoadE, RegWriteM, RegWriteW;
  logic             RVPCSrcE, BranchTakenE;
  logic             PCWriteD, PCSrcE, PCSrcW;
  logic             DmemReadyM;

  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  fwd_sel_t         ForwardAE, ForwardBE;

  modport master (
    output arm, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           LoadE, RegWriteM, RegWriteW, RVPCSrcE, BranchTakenE,
           PCWriteD, PCSrcE, PCSrcW, DmemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE
  );

  modport slave (
    input  arm, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
           LoadE, RegWriteM, RegWriteW, RVPCSrcE, BranchTakenE,
           PCWriteD, PCSrcE, PCSrcW, DmemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE
  );

endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// ALU operand forwarding select for one source register; purely combinational.
// M stage wins over W; ARM R15 and RISC-V x0 are never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int PC_REG = PC_REG_DEF
) (
  input  logic             arm,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rdM,
  input  logic [REG_W-1:0] rdW,
  input  logic             regWriteM,
  input  logic             regWriteW,
  output fwd_sel_t         sel
);

  localparam logic [3:0] PC_IDX = 4'(PC_REG);

  // ARM only has 16 registers, so bit 4 is ignored in that mode.
  function automatic logic regEq(input logic a, input logic [REG_W-1:0] x,
                                 input logic [REG_W-1:0] y);
    return a ? (x[3:0] == y[3:0]) : (x == y);
  endfunction

  function automatic logic regValid(input logic a, input logic [REG_W-1:0] r);
    return a ? (r[3:0] != PC_IDX) : (r != '0);
  endfunction

  logic hitM, hitW;

  assign hitM = regWriteM & regEq(arm, rdM, rs) & regValid(arm, rdM);
  assign hitW = regWriteW & regEq(arm, rdW, rs) & regValid(arm, rdW);

  always_comb begin
    sel = FWD_RF;
    if (hitM)      sel = FWD_M;
    else if (hitW) sel = FWD_W;
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward controller for the dual-ISA 5-stage core; controls are same-cycle combinational.
// Only the ARM R15-write sequencer state is registered; a data-memory wait freezes F..M and the FSM.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int PC_REG = PC_REG_DEF
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  hz_state_t state;
  fwd_sel_t  selA, selB;
  logic      redirect, ldStall, ldHit;

  function automatic logic regEq(input logic a, input logic [REG_W-1:0] x,
                                 input logic [REG_W-1:0] y);
    return a ? (x[3:0] == y[3:0]) : (x == y);
  endfunction

  fwd_sel #(.REG_W(REG_W), .PC_REG(PC_REG)) u_fwdA (
    .arm(hz.arm), .rs(hz.Rs1E), .rdM(hz.RdM), .rdW(hz.RdW),
    .regWriteM(hz.RegWriteM), .regWriteW(hz.RegWriteW), .sel(selA)
  );

  fwd_sel #(.REG_W(REG_W), .PC_REG(PC_REG)) u_fwdB (
    .arm(hz.arm), .rs(hz.Rs2E), .rdM(hz.RdM), .rdW(hz.RdW),
    .regWriteM(hz.RegWriteM), .regWriteW(hz.RegWriteW), .sel(selB)
  );

  assign redirect = hz.arm ? hz.BranchTakenE : hz.RVPCSrcE;
  assign ldHit    = regEq(hz.arm, hz.RdE, hz.Rs1D) | regEq(hz.arm, hz.RdE, hz.Rs2D);
  assign ldStall  = hz.LoadE & ldHit & (hz.arm | (hz.RdE != '0));

  // R15 write sequencer: hold fetch until the new PC reaches W.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (hz.DmemReadyM) begin
      unique case (state)
        RUN:   if (hz.arm & hz.PCWriteD & ~redirect & ~ldStall) state <= PCW_E;
        PCW_E: state <= (hz.arm & hz.PCSrcE) ? PCW_M : RUN;
        PCW_M: state <= hz.arm ? PCW_W : RUN;
        PCW_W: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushW    = 1'b0;
    hz.ForwardAE = rst ? FWD_RF : selA;
    hz.ForwardBE = rst ? FWD_RF : selB;

    if (rst) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (~hz.DmemReadyM) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (redirect) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (state != RUN) begin
      // Fetch runs again once the write is known dead (PCW_E abort) or lands (PCW_W).
      hz.FlushD = 1'b1;
      hz.StallF = ~(((state == PCW_E) & ~hz.PCSrcE) | (state == PCW_W));
    end else if (ldStall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; FSM state is inferred from the stall/flush pattern.
module tb_hazard_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   nTests = 0;
  int   nFails = 0;

  always #5 clk = ~clk;

  hazard_if #(.REG_W(5)) hif ();

  hazard_unit #(.REG_W(5), .PC_REG(15)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif.slave)
  );

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [6:0] ctl;
  assign ctl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                hif.FlushD, hif.FlushE, hif.FlushW};

  localparam logic [6:0] C_IDLE  = 7'b0000_000;
  localparam logic [6:0] C_RST   = 7'b0000_110;
  localparam logic [6:0] C_LD    = 7'b1100_010;
  localparam logic [6:0] C_WAIT  = 7'b1111_001;
  localparam logic [6:0] C_PCWS  = 7'b1000_100;
  localparam logic [6:0] C_PCWR  = 7'b0000_100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clearIn();
    hif.arm = 1'b0;
    hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0;
    hif.RdE = '0;  hif.RdM = '0;  hif.RdW = '0;
    hif.LoadE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.RVPCSrcE = 1'b0; hif.BranchTakenE = 1'b0;
    hif.PCWriteD = 1'b0; hif.PCSrcE = 1'b0; hif.PCSrcW = 1'b0;
    hif.DmemReadyM = 1'b1;
  endtask

  // Issues an ARM R15 writer in D (RUN) and leaves the bench at the start of the PCW_E cycle.
  task automatic enterPcwE(input string tag);
    clearIn(); hif.arm = 1'b1; hif.PCWriteD = 1'b1;
    settle(); check({tag, "_run"}, ctl, C_IDLE);
    cyc(); clearIn(); hif.arm = 1'b1;
  endtask

  initial begin
    clearIn();
    rst = 1'b1;
    hif.RdM = 5'd5; hif.RegWriteM = 1'b1; hif.Rs1E = 5'd5;
    cyc(); settle(); check("rst_ctl0", ctl, C_RST);
    cyc(); settle(); check("rst_ctl1", ctl, C_RST);
    check("rst_fwdA", hif.ForwardAE, 2'b00);
    cyc(); rst = 1'b0; clearIn();
    settle(); check("rst_release", ctl, C_IDLE);

    // Forwarding, RISC-V
    cyc(); hif.RdM = 5'd5; hif.RegWriteM = 1'b1; hif.RdW = 5'd5; hif.RegWriteW = 1'b1;
    hif.Rs1E = 5'd5; hif.Rs2E = 5'd5;
    settle(); check("rv_fwdA_M", hif.ForwardAE, 2'b10); check("rv_fwdB_M", hif.ForwardBE, 2'b10);
    hif.RegWriteM = 1'b0;
    settle(); check("rv_fwdA_W", hif.ForwardAE, 2'b01);
    hif.RegWriteM = 1'b1; hif.RdM = 5'd0; hif.RdW = 5'd0; hif.Rs1E = 5'd0;
    settle(); check("rv_fwdA_x0", hif.ForwardAE, 2'b00);
    hif.RdM = 5'd3; hif.Rs1E = 5'h13;
    settle(); check("rv_fwd_bit4", hif.ForwardAE, 2'b00);

    // Forwarding, ARM
    cyc(); clearIn(); hif.arm = 1'b1;
    hif.RegWriteW = 1'b1; hif.RdW = 5'd15; hif.Rs2E = 5'd15;
    settle(); check("arm_fwdB_r15", hif.ForwardBE, 2'b00);
    hif.RdW = 5'd0; hif.Rs2E = 5'd0;
    settle(); check("arm_fwdB_r0", hif.ForwardBE, 2'b01);
    hif.RegWriteM = 1'b1; hif.RdM = 5'd3; hif.Rs1E = 5'h13;
    settle(); check("arm_fwdA_lo4", hif.ForwardAE, 2'b10);

    // Load-use
    cyc(); clearIn(); hif.LoadE = 1'b1; hif.RdE = 5'd3; hif.Rs2D = 5'd3;
    settle(); check("ld_stall", ctl, C_LD);
    cyc(); hif.LoadE = 1'b0;
    settle(); check("ld_release", ctl, C_IDLE);
    hif.LoadE = 1'b1; hif.RdE = 5'd0; hif.Rs1D = 5'd0; hif.Rs2D = 5'd7;
    settle(); check("ld_rv_x0", ctl, C_IDLE);
    hif.arm = 1'b1;
    settle(); check("ld_arm_r0", ctl, C_LD);

    // Redirect
    cyc(); clearIn(); hif.LoadE = 1'b1; hif.RdE = 5'd3; hif.Rs2D = 5'd3; hif.RVPCSrcE = 1'b1;
    settle(); check("redir_rv", ctl, C_RST);
    cyc(); clearIn(); hif.arm = 1'b1; hif.BranchTakenE = 1'b1; hif.PCWriteD = 1'b1;
    settle(); check("redir_arm", ctl, C_RST);
    cyc(); clearIn(); hif.arm = 1'b1;
    settle(); check("redir_no_pcw", ctl, C_IDLE);

    // ARM R15 write, condition passes
    cyc(); enterPcwE("pcw");
    hif.PCSrcE = 1'b1;
    settle(); check("pcw_E", ctl, C_PCWS);
    cyc(); clearIn(); hif.arm = 1'b1;
    settle(); check("pcw_M", ctl, C_PCWS);
    cyc(); hif.PCSrcW = 1'b1;
    settle(); check("pcw_W", ctl, C_PCWR);
    cyc(); clearIn(); hif.arm = 1'b1;
    settle(); check("pcw_done", ctl, C_IDLE);

    // ARM R15 write, condition fails
    cyc(); enterPcwE("abort");
    settle(); check("abort_E", ctl, C_PCWR);
    cyc();
    settle(); check("abort_done", ctl, C_IDLE);

    // Memory wait holds PCW_M
    cyc(); enterPcwE("mw");
    hif.PCSrcE = 1'b1;
    settle(); check("mw_E", ctl, C_PCWS);
    cyc(); hif.PCSrcE = 1'b0; hif.DmemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle(); check($sformatf("mw_wait%0d", i), ctl, C_WAIT);
      cyc();
    end
    hif.DmemReadyM = 1'b1;
    settle(); check("mw_M_held", ctl, C_PCWS);
    cyc();
    settle(); check("mw_W", ctl, C_PCWR);
    cyc();
    settle(); check("mw_done", ctl, C_IDLE);

    // Reset in PCW_M abandons the sequence
    cyc(); enterPcwE("rm");
    hif.PCSrcE = 1'b1;
    cyc(); clearIn(); hif.arm = 1'b1; rst = 1'b1;
    settle(); check("rm_rst", ctl, C_RST);
    cyc(); rst = 1'b0;
    settle(); check("rm_run", ctl, C_IDLE);

    // Mode switch to RISC-V leaves PCW_E
    cyc(); enterPcwE("md");
    hif.PCSrcE = 1'b1; hif.arm = 1'b0;
    settle(); check("md_E", ctl, C_PCWS);
    cyc(); clearIn();
    settle(); check("md_run", ctl, C_IDLE);

    // Memory wait beats redirect and blocks FSM entry
    cyc(); clearIn(); hif.arm = 1'b1; hif.PCWriteD = 1'b1; hif.BranchTakenE = 1'b0;
    hif.DmemReadyM = 1'b0;
    settle(); check("mw_run_entry", ctl, C_WAIT);
    cyc(); clearIn(); hif.RVPCSrcE = 1'b1; hif.DmemReadyM = 1'b0;
    settle(); check("mw_redir", ctl, C_WAIT);
    cyc(); clearIn();
    settle(); check("mw_no_entry", ctl, C_IDLE);

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
